// File: rtl/lms_pkg.sv
// Shared definitions for the LMS weight-update block.
// Holds the tap count, datapath widths, the update-FSM state type, the
// saturation limits and the helper that clamps a wide sum into a weight.
// Every file in this slice imports it with import lms_pkg::*.
package lms_pkg;

   // Default number of filter taps / weights.
   localparam int NTAPS  = 16;

   // Number of physical reff_k / weight_out_k ports on the top level.
   localparam int NPORTS = 16;

   // Datapath widths: error sample, reference sample, weight.
   localparam int E_W = 32;
   localparam int R_W = 14;
   localparam int W_W = 32;

   // Full-precision product width (e * tap).
   localparam int P_W = E_W + R_W;

   // Sum width: one guard bit above the product width.
   // An unshifted product (MU_SHIFT = 0) plus a weight cannot wrap
   // before it is clamped.
   localparam int S_W = P_W + 1;

   localparam logic signed [W_W-1:0] SAT_MAX = 32'sh7FFF_FFFF;
   localparam logic signed [W_W-1:0] SAT_MIN = 32'sh8000_0000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      UPD  = 2'd1,
      DONE = 2'd2
   } lms_state_t;

   // Clamp a wide signed sum into the signed weight range.
   function automatic logic signed [W_W-1:0] sat_w(input logic signed [S_W-1:0] value);
      logic signed [S_W-1:0] hi;
      logic signed [S_W-1:0] lo;
      hi = {{(S_W-W_W){SAT_MAX[W_W-1]}}, SAT_MAX};
      lo = {{(S_W-W_W){SAT_MIN[W_W-1]}}, SAT_MIN};
      if (value > hi) begin
         sat_w = SAT_MAX;
      end else if (value < lo) begin
         sat_w = SAT_MIN;
      end else begin
         sat_w = value[W_W-1:0];
      end
   endfunction

endpackage

// File: rtl/lms_mac_sat.sv
// Combinational multiply / shift / add / saturate for one LMS weight.
// This block contains the only multiplier in the design.
// Ports:
//   e           - latched error sample (signed)
//   tap         - selected reference tap (signed)
//   weight      - selected current weight (signed)
//   weight_next - sat(weight + ((e * tap) >>> MU_SHIFT))
module lms_mac_sat
   import lms_pkg::*;
#(
   parameter int MU_SHIFT = 20
) (
   input  logic signed [E_W-1:0] e,
   input  logic signed [R_W-1:0] tap,
   input  logic signed [W_W-1:0] weight,
   output logic signed [W_W-1:0] weight_next
);

   logic signed [P_W-1:0] product;
   logic signed [P_W-1:0] delta;
   logic signed [S_W-1:0] sum;

   // Full 46-bit signed product of the error and the tap.
   assign product = e * tap;

   // Arithmetic shift rounds toward minus infinity.
   // For example, e = -1 still yields a delta of -1.
   assign delta = product >>> MU_SHIFT;

   // The sum is widened past 33 bits.
   // An unshifted full-scale product then saturates instead of wrapping.
   // Whenever the delta fits in 32 bits, this matches a 33-bit sum exactly.
   assign sum = S_W'(weight) + S_W'(delta);

   assign weight_next = sat_w(sum);

endmodule

// File: rtl/lms_weight_update.sv
// Serial LMS weight updater.
// A pass starts on upd_start. The block then snapshots the error and all
// reference taps, and updates one weight per cycle through a single shared
// MAC/saturate unit. Finally it pulses done for one cycle.
// Ports:
//   clk, rst            - clock; synchronous active-high reset
//   upd_start           - one-cycle request; e and reff_k are valid with it
//   clear               - synchronous load of W_INIT into all weights; aborts a pass
//   e                   - error sample (signed 32-bit)
//   reff_0 .. reff_15   - reference tap samples (signed 14-bit)
//   weight_out_0 .. _15 - current weights, straight from the weight registers
//   busy                - high during UPD and DONE
//   done                - one-cycle pulse when a pass completes
// NTAPS must not exceed the 16 physical tap ports.
module lms_weight_update
   import lms_pkg::*;
#(
   parameter int          NTAPS    = lms_pkg::NTAPS,
   parameter int          MU_SHIFT = 20,
   parameter logic [31:0] W_INIT   = 32'd0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  upd_start,
   input  logic                  clear,
   input  logic signed [E_W-1:0] e,
   input  logic signed [R_W-1:0] reff_0,
   input  logic signed [R_W-1:0] reff_1,
   input  logic signed [R_W-1:0] reff_2,
   input  logic signed [R_W-1:0] reff_3,
   input  logic signed [R_W-1:0] reff_4,
   input  logic signed [R_W-1:0] reff_5,
   input  logic signed [R_W-1:0] reff_6,
   input  logic signed [R_W-1:0] reff_7,
   input  logic signed [R_W-1:0] reff_8,
   input  logic signed [R_W-1:0] reff_9,
   input  logic signed [R_W-1:0] reff_10,
   input  logic signed [R_W-1:0] reff_11,
   input  logic signed [R_W-1:0] reff_12,
   input  logic signed [R_W-1:0] reff_13,
   input  logic signed [R_W-1:0] reff_14,
   input  logic signed [R_W-1:0] reff_15,
   output logic signed [W_W-1:0] weight_out_0,
   output logic signed [W_W-1:0] weight_out_1,
   output logic signed [W_W-1:0] weight_out_2,
   output logic signed [W_W-1:0] weight_out_3,
   output logic signed [W_W-1:0] weight_out_4,
   output logic signed [W_W-1:0] weight_out_5,
   output logic signed [W_W-1:0] weight_out_6,
   output logic signed [W_W-1:0] weight_out_7,
   output logic signed [W_W-1:0] weight_out_8,
   output logic signed [W_W-1:0] weight_out_9,
   output logic signed [W_W-1:0] weight_out_10,
   output logic signed [W_W-1:0] weight_out_11,
   output logic signed [W_W-1:0] weight_out_12,
   output logic signed [W_W-1:0] weight_out_13,
   output logic signed [W_W-1:0] weight_out_14,
   output logic signed [W_W-1:0] weight_out_15,
   output logic                  busy,
   output logic                  done
);

   localparam int IDX_W = (NTAPS > 1) ? $clog2(NTAPS) : 1;

   lms_state_t state;
   lms_state_t state_next;

   logic        [IDX_W-1:0] idx;
   logic signed [E_W-1:0]   e_lat;
   logic signed [R_W-1:0]   tap      [NTAPS];
   logic signed [W_W-1:0]   w        [NTAPS];
   logic signed [R_W-1:0]   reff_in  [NPORTS];
   logic signed [W_W-1:0]   w_port   [NPORTS];
   logic signed [R_W-1:0]   tap_sel;
   logic signed [W_W-1:0]   w_sel;
   logic signed [W_W-1:0]   w_new;
   logic                    last_tap;

   // Gather the flat tap ports into an array for indexed snapshotting.
   assign reff_in[0]  = reff_0;
   assign reff_in[1]  = reff_1;
   assign reff_in[2]  = reff_2;
   assign reff_in[3]  = reff_3;
   assign reff_in[4]  = reff_4;
   assign reff_in[5]  = reff_5;
   assign reff_in[6]  = reff_6;
   assign reff_in[7]  = reff_7;
   assign reff_in[8]  = reff_8;
   assign reff_in[9]  = reff_9;
   assign reff_in[10] = reff_10;
   assign reff_in[11] = reff_11;
   assign reff_in[12] = reff_12;
   assign reff_in[13] = reff_13;
   assign reff_in[14] = reff_14;
   assign reff_in[15] = reff_15;

   // The index mux feeds the single MAC with the current tap and weight.
   assign tap_sel  = tap[idx];
   assign w_sel    = w[idx];
   assign last_tap = (idx == IDX_W'(NTAPS - 1));

   lms_mac_sat #(
      .MU_SHIFT (MU_SHIFT)
   ) u_mac (
      .e           (e_lat),
      .tap         (tap_sel),
      .weight      (w_sel),
      .weight_next (w_new)
   );

   // Next-state logic and status outputs.
   // Clear overrides everything except reset.
   // Because of that override, a start arriving together with clear is dropped.
   always_comb begin
      state_next = state;
      busy       = 1'b0;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (upd_start) begin
               state_next = UPD;
            end
         end
         UPD: begin
            busy = 1'b1;
            if (last_tap) begin
               state_next = DONE;
            end
         end
         DONE: begin
            busy       = 1'b1;
            done       = 1'b1;
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      if (clear) begin
         state_next = IDLE;
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Datapath registers.
   // The error and the taps are captured only when a pass starts from IDLE.
   // Input changes during UPD, or a second start, therefore cannot disturb
   // a pass that is already running.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx   <= '0;
         e_lat <= '0;
         for (int k = 0; k < NTAPS; k++) begin
            tap[k] <= '0;
            w[k]   <= W_INIT;
         end
      end else if (clear) begin
         idx <= '0;
         for (int k = 0; k < NTAPS; k++) begin
            w[k] <= W_INIT;
         end
      end else begin
         case (state)
            IDLE: begin
               if (upd_start) begin
                  idx   <= '0;
                  e_lat <= e;
                  for (int k = 0; k < NTAPS; k++) begin
                     tap[k] <= reff_in[k];
                  end
               end
            end
            UPD: begin
               w[idx] <= w_new;
               if (last_tap) begin
                  idx <= '0;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Unused port slots read as zero when NTAPS < 16.
   for (genvar k = 0; k < NPORTS; k++) begin : g_wport
      if (k < NTAPS) begin : g_used
         assign w_port[k] = w[k];
      end else begin : g_unused
         assign w_port[k] = '0;
      end
   end

   assign weight_out_0  = w_port[0];
   assign weight_out_1  = w_port[1];
   assign weight_out_2  = w_port[2];
   assign weight_out_3  = w_port[3];
   assign weight_out_4  = w_port[4];
   assign weight_out_5  = w_port[5];
   assign weight_out_6  = w_port[6];
   assign weight_out_7  = w_port[7];
   assign weight_out_8  = w_port[8];
   assign weight_out_9  = w_port[9];
   assign weight_out_10 = w_port[10];
   assign weight_out_11 = w_port[11];
   assign weight_out_12 = w_port[12];
   assign weight_out_13 = w_port[13];
   assign weight_out_14 = w_port[14];
   assign weight_out_15 = w_port[15];

endmodule

// File: tb/tb_lms_weight_update.sv
// Directed testbench for lms_weight_update.
// The main instance uses the default parameters.
// Two further instances (MU_SHIFT = 0, preloaded W_INIT) exercise the
// saturation limits.
module tb_lms_weight_update;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic               rst;
   logic               clear;
   logic               upd_start;
   logic               upd_sat;
   logic signed [31:0] e;
   logic signed [13:0] reff [16];
   logic signed [13:0] reff_hi;
   logic signed [13:0] reff_lo;
   logic signed [31:0] w    [16];
   logic signed [31:0] w_hi [16];
   logic signed [31:0] w_lo [16];
   logic               busy, done, busy_hi, done_hi, busy_lo, done_lo;

   int tests_run    = 0;
   int tests_failed = 0;
   int busy_seen    = 0;
   int done_seen    = 0;

   lms_weight_update dut (
      .clk(clk), .rst(rst), .upd_start(upd_start), .clear(clear), .e(e),
      .reff_0(reff[0]), .reff_1(reff[1]), .reff_2(reff[2]), .reff_3(reff[3]),
      .reff_4(reff[4]), .reff_5(reff[5]), .reff_6(reff[6]), .reff_7(reff[7]),
      .reff_8(reff[8]), .reff_9(reff[9]), .reff_10(reff[10]), .reff_11(reff[11]),
      .reff_12(reff[12]), .reff_13(reff[13]), .reff_14(reff[14]), .reff_15(reff[15]),
      .weight_out_0(w[0]), .weight_out_1(w[1]), .weight_out_2(w[2]), .weight_out_3(w[3]),
      .weight_out_4(w[4]), .weight_out_5(w[5]), .weight_out_6(w[6]), .weight_out_7(w[7]),
      .weight_out_8(w[8]), .weight_out_9(w[9]), .weight_out_10(w[10]), .weight_out_11(w[11]),
      .weight_out_12(w[12]), .weight_out_13(w[13]), .weight_out_14(w[14]), .weight_out_15(w[15]),
      .busy(busy), .done(done)
   );

   lms_weight_update #(.MU_SHIFT(0), .W_INIT(32'h7FFF_FFF0)) dut_hi (
      .clk(clk), .rst(rst), .upd_start(upd_sat), .clear(1'b0), .e(e),
      .reff_0(reff_hi), .reff_1(reff_hi), .reff_2(reff_hi), .reff_3(reff_hi),
      .reff_4(reff_hi), .reff_5(reff_hi), .reff_6(reff_hi), .reff_7(reff_hi),
      .reff_8(reff_hi), .reff_9(reff_hi), .reff_10(reff_hi), .reff_11(reff_hi),
      .reff_12(reff_hi), .reff_13(reff_hi), .reff_14(reff_hi), .reff_15(reff_hi),
      .weight_out_0(w_hi[0]), .weight_out_1(w_hi[1]), .weight_out_2(w_hi[2]), .weight_out_3(w_hi[3]),
      .weight_out_4(w_hi[4]), .weight_out_5(w_hi[5]), .weight_out_6(w_hi[6]), .weight_out_7(w_hi[7]),
      .weight_out_8(w_hi[8]), .weight_out_9(w_hi[9]), .weight_out_10(w_hi[10]), .weight_out_11(w_hi[11]),
      .weight_out_12(w_hi[12]), .weight_out_13(w_hi[13]), .weight_out_14(w_hi[14]), .weight_out_15(w_hi[15]),
      .busy(busy_hi), .done(done_hi)
   );

   lms_weight_update #(.MU_SHIFT(0), .W_INIT(32'h8000_0010)) dut_lo (
      .clk(clk), .rst(rst), .upd_start(upd_sat), .clear(1'b0), .e(e),
      .reff_0(reff_lo), .reff_1(reff_lo), .reff_2(reff_lo), .reff_3(reff_lo),
      .reff_4(reff_lo), .reff_5(reff_lo), .reff_6(reff_lo), .reff_7(reff_lo),
      .reff_8(reff_lo), .reff_9(reff_lo), .reff_10(reff_lo), .reff_11(reff_lo),
      .reff_12(reff_lo), .reff_13(reff_lo), .reff_14(reff_lo), .reff_15(reff_lo),
      .weight_out_0(w_lo[0]), .weight_out_1(w_lo[1]), .weight_out_2(w_lo[2]), .weight_out_3(w_lo[3]),
      .weight_out_4(w_lo[4]), .weight_out_5(w_lo[5]), .weight_out_6(w_lo[6]), .weight_out_7(w_lo[7]),
      .weight_out_8(w_lo[8]), .weight_out_9(w_lo[9]), .weight_out_10(w_lo[10]), .weight_out_11(w_lo[11]),
      .weight_out_12(w_lo[12]), .weight_out_13(w_lo[13]), .weight_out_14(w_lo[14]), .weight_out_15(w_lo[15]),
      .busy(busy_lo), .done(done_lo)
   );

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Advance to the falling edge after the next rising edge and tally status.
   task automatic stepCycle();
      @(negedge clk);
      if (busy) busy_seen++;
      if (done) done_seen++;
   endtask

   task automatic runCycles(input int n);
      for (int i = 0; i < n; i++) stepCycle();
   endtask

   // Pulse upd_start for one cycle with the given error.
   // On return the start edge (edge 0) has just been sampled.
   task automatic applyStimulus(input logic signed [31:0] e_val);
      e         = e_val;
      upd_start = 1'b1;
      busy_seen = 0;
      done_seen = 0;
      stepCycle();
      upd_start = 1'b0;
   endtask

   task automatic setReffAll(input int val);
      for (int k = 0; k < 16; k++) reff[k] = 14'(val);
   endtask

   task automatic pulseClear();
      clear = 1'b1;
      stepCycle();
      clear = 1'b0;
   endtask

   initial begin
      rst       = 1'b1;
      clear     = 1'b0;
      upd_start = 1'b0;
      upd_sat   = 1'b0;
      e         = '0;
      reff_hi   = 14'sd8191;
      reff_lo   = -14'sd8192;
      setReffAll(0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state.
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      for (int k = 0; k < 16; k++) checkOutput($sformatf("rst_w%0d", k), w[k], 32'd0);
      checkOutput("rst_w_hi0", w_hi[0], 32'h7FFF_FFF0);
      checkOutput("rst_w_lo0", w_lo[0], 32'h8000_0010);

      // Saturation at both rails with an unshifted full-scale product.
      e       = 32'sh7FFF_FFFF;
      upd_sat = 1'b1;
      stepCycle();
      upd_sat = 1'b0;
      runCycles(19);
      for (int k = 0; k < 16; k++) begin
         checkOutput($sformatf("sat_hi_w%0d", k), w_hi[k], 32'h7FFF_FFFF);
         checkOutput($sformatf("sat_lo_w%0d", k), w_lo[k], 32'h8000_0000);
      end

      // e = 2^20 and unit taps: every weight becomes 1.
      // Also checks latency and the done timing.
      setReffAll(1);
      applyStimulus(32'sd1048576);
      checkOutput("lat_w0_edge0", w[0], 32'd0);
      stepCycle();
      checkOutput("lat_w0_edge1", w[0], 32'd1);
      checkOutput("lat_w1_edge1", w[1], 32'd0);
      runCycles(14);
      checkOutput("lat_w15_edge15", w[15], 32'd0);
      checkOutput("done_edge15", 32'(done), 32'd0);
      stepCycle();
      checkOutput("done_edge16", 32'(done), 32'd1);
      checkOutput("w15_edge16", w[15], 32'd1);
      runCycles(3);
      checkOutput("unit_busy_cycles", 32'(busy_seen), 32'd17);
      checkOutput("unit_done_pulses", 32'(done_seen), 32'd1);
      for (int k = 0; k < 16; k++) checkOutput($sformatf("unit_w%0d", k), w[k], 32'd1);

      // Negative error with ramp taps gives -k, then -2k after a second pass.
      pulseClear();
      for (int k = 0; k < 16; k++) checkOutput($sformatf("clr_w%0d", k), w[k], 32'd0);
      for (int k = 0; k < 16; k++) reff[k] = 14'(k);
      applyStimulus(-32'sd1048576);
      runCycles(19);
      for (int k = 0; k < 16; k++) checkOutput($sformatf("ramp1_w%0d", k), w[k], 32'(-k));
      applyStimulus(-32'sd1048576);
      runCycles(19);
      for (int k = 0; k < 16; k++) checkOutput($sformatf("ramp2_w%0d", k), w[k], 32'(-2 * k));

      // Floor shift: e = -1 decrements by one; e = 1 leaves the weights alone.
      pulseClear();
      setReffAll(1);
      applyStimulus(-32'sd1);
      runCycles(19);
      for (int k = 0; k < 16; k++) checkOutput($sformatf("floor_neg_w%0d", k), w[k], 32'hFFFF_FFFF);
      applyStimulus(32'sd1);
      runCycles(19);
      for (int k = 0; k < 16; k++) checkOutput($sformatf("floor_pos_w%0d", k), w[k], 32'hFFFF_FFFF);

      // A second start mid-pass and tap changes mid-pass must be ignored.
      pulseClear();
      for (int k = 0; k < 16; k++) reff[k] = 14'(k + 1);
      applyStimulus(32'sd3145728);
      runCycles(4);
      e         = 32'sd7340032;
      upd_start = 1'b1;
      setReffAll(100);
      stepCycle();
      upd_start = 1'b0;
      runCycles(14);
      checkOutput("snap_busy_cycles", 32'(busy_seen), 32'd17);
      checkOutput("snap_done_pulses", 32'(done_seen), 32'd1);
      for (int k = 0; k < 16; k++) checkOutput($sformatf("snap_w%0d", k), w[k], 32'(3 * (k + 1)));

      // Clear together with start: clear wins and no pass begins.
      busy_seen = 0;
      done_seen = 0;
      setReffAll(1);
      e         = 32'sd1048576;
      clear     = 1'b1;
      upd_start = 1'b1;
      stepCycle();
      clear     = 1'b0;
      upd_start = 1'b0;
      runCycles(5);
      checkOutput("clrstart_busy", 32'(busy_seen), 32'd0);
      for (int k = 0; k < 16; k++) checkOutput($sformatf("clrstart_w%0d", k), w[k], 32'd0);

      // Clear at cycle 8 of a pass aborts it without a done pulse.
      setReffAll(5);
      applyStimulus(32'sd1048576);
      runCycles(19);
      checkOutput("pre_clr_w15", w[15], 32'd5);
      applyStimulus(32'sd1048576);
      runCycles(7);
      checkOutput("mid_clr_w0", w[0], 32'd10);
      pulseClear();
      checkOutput("abort_clr_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 16; k++) checkOutput($sformatf("abort_clr_w%0d", k), w[k], 32'd0);
      runCycles(12);
      checkOutput("abort_clr_done", 32'(done_seen), 32'd0);

      // Reset at cycle 8 of a pass behaves the same way.
      applyStimulus(32'sd1048576);
      runCycles(19);
      checkOutput("pre_rst_w15", w[15], 32'd5);
      applyStimulus(32'sd1048576);
      runCycles(7);
      rst = 1'b1;
      stepCycle();
      rst = 1'b0;
      checkOutput("abort_rst_busy", 32'(busy), 32'd0);
      for (int k = 0; k < 16; k++) checkOutput($sformatf("abort_rst_w%0d", k), w[k], 32'd0);
      runCycles(12);
      checkOutput("abort_rst_done", 32'(done_seen), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/lms_weight_update.md
LMS_WEIGHT_UPDATE -- requirements
Module: lms_weight_update

Interface
REQ-001 SHALL have parameter NTAPS, default 16, meaning the number of filter taps and weights.
REQ-002 SHALL have parameter MU_SHIFT, default 20, meaning the step-size right shift applied to each update product.
REQ-003 SHALL have parameter W_INIT, default 32'd0, meaning the weight value loaded at reset and on clear.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, the reset; synchronous and active-high.
REQ-006 SHALL have port upd_start, input, 1 bit, a one-cycle pulse meaning e is valid and an update pass is requested.
REQ-007 SHALL have port clear, input, 1 bit, a synchronous request to load W_INIT into all weights.
REQ-008 SHALL have port e, input, 32 bits, the error sample; signed two's complement.
REQ-009 SHALL have ports reff_0 .. reff_15, input, 14 bits each, the reference tap samples; signed two's complement.
REQ-010 SHALL have ports weight_out_0 .. weight_out_15, output, 32 bits each, the current weights; signed; these drive the filter's weight_in_0 .. weight_in_15.
REQ-011 SHALL have port busy, output, 1 bit, high while an update pass is in progress.
REQ-012 SHALL have port done, output, 1 bit, a one-cycle pulse when a pass completes.

Function
REQ-013 SHALL implement the state machine IDLE -> UPD -> DONE -> IDLE.
REQ-014 In IDLE, upd_start=1 SHALL latch e into e_lat, snapshot all reff_k into tap registers, set idx=0, and enter UPD.
REQ-015 In UPD, each cycle SHALL perform w[idx] <= sat32(w[idx] + ((e_lat * tap[idx]) >>> MU_SHIFT)), then increment idx.
REQ-016 In UPD, when idx=NTAPS-1 the transition SHALL go to DONE; DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-017 Latency: with upd_start sampled at edge 0, w[k] SHALL change at edge k+1, and done SHALL be high in the cycle after edge 16.
REQ-018 busy SHALL be 1 in UPD and DONE, and 0 in IDLE.
REQ-019 Arithmetic: the product SHALL be a 46-bit signed value; the shift SHALL be arithmetic (rounding toward -inf); the sum SHALL be formed at 33 bits and saturated to [-2^31, 2^31-1].
REQ-020 upd_start while busy=1 SHALL be ignored, with no queuing and no effect on e_lat.
REQ-021 Changes on e or reff_k during UPD SHALL NOT affect the pass in progress (snapshot semantics).
REQ-022 clear=1 SHALL load W_INIT into all weights on the next edge, abort any pass, and return to IDLE with done=0.
REQ-023 clear=1 with simultaneous upd_start SHALL give clear priority; the start SHALL be dropped.
REQ-024 weight_out_k SHALL be driven directly from the weight registers, with no combinational path from any input.

Reset
REQ-025 rst=1 at a rising edge SHALL set the state to IDLE, idx=0, e_lat=0, all taps to 0, all weights to W_INIT, and busy=0, done=0.
REQ-026 rst SHALL take priority over clear and upd_start.
REQ-027 rst asserted mid-pass SHALL discard the pass without producing a done pulse.

Structure
REQ-028 NTAPS, the widths (E_W=32, R_W=14, W_W=32), the state enum, and the SAT_MAX/SAT_MIN constants SHALL reside in shared package lms_pkg.
REQ-029 Multiply-shift-add-saturate SHALL be one combinational sub-module, lms_mac_sat, instantiated once; the index mux selects the tap and weight.
REQ-030 Exactly one multiplier SHALL exist; serial processing over idx is mandatory.

Verification
REQ-031 Reset, then e=1048576 (2^20), all reff=1, one upd_start -> after 17 cycles every weight = 1, done pulses once, busy high for 17 cycles.
REQ-032 e=-1048576, reff_k=k -> weight_out_k = -k after the pass; a second pass gives -2k.
REQ-033 MU_SHIFT=0, weights preloaded to 0x7FFFFFF0 via W_INIT, e=0x7FFFFFFF, reff=8191 -> all weights saturate at 0x7FFFFFFF; with reff=-8192 and W_INIT=0x80000010 -> 0x80000000.
REQ-034 e=-1, reff=1, MU_SHIFT=20 -> each weight decrements by 1 (floor shift); e=1 -> weights unchanged.
REQ-035 Second upd_start at cycle 5 of a pass, with reff toggled mid-pass -> results identical to the undisturbed pass, and a single done pulse.
REQ-036 clear at cycle 8 of a pass -> all weights = W_INIT next cycle, busy=0, no done pulse; rst at cycle 8 gives the same outcome.
